// File: rtl/study_index_tracker.sv
// Study-mode score follower: debounces key codes, scores each accepted press as hit/miss
// and advances the song index. Define STUDY_MISS_COUNT_EN to build the saturating miss counter.
module study_index_tracker #(
    parameter int unsigned NOTE_W     = 10,
    parameter int unsigned IDX_W      = 7,
    parameter int unsigned START_IDX  = 1,
    parameter int unsigned SONG_LEN   = 100,
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              restart,
    input  logic [NOTE_W-1:0] expected_note,
    input  logic [NOTE_W-1:0] key_in,
    output logic [IDX_W-1:0]  index,
    output logic              hit,
    output logic              miss,
    output logic              done,
    output logic [7:0]        miss_count
);

    localparam int unsigned CNT_W = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
    localparam logic [IDX_W-1:0] START_V  = IDX_W'(START_IDX);
    localparam logic [IDX_W-1:0] LAST_V   = IDX_W'(SONG_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((STABLE_CYC >= 2) ? (STABLE_CYC - 2) : 0);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        CONFIRM = 3'd2,
        HELD    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [NOTE_W-1:0]  cand, cand_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [IDX_W-1:0]   index_nxt;
    logic               hit_nxt, miss_nxt, done_nxt;
    logic               key_zero;
    logic               accept;

    assign key_zero = (key_in == '0);

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cand  <= '0;
            cnt   <= '0;
            index <= START_V;
            hit   <= 1'b0;
            miss  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cand  <= cand_nxt;
            cnt   <= cnt_nxt;
            index <= index_nxt;
            hit   <= hit_nxt;
            miss  <= miss_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state and output decode; restart overrides en
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        index_nxt = index;
        hit_nxt   = 1'b0;
        miss_nxt  = 1'b0;
        done_nxt  = done;
        accept    = 1'b0;

        if (restart) begin
            state_nxt = IDLE;
            cand_nxt  = '0;
            cnt_nxt   = '0;
            index_nxt = START_V;
            done_nxt  = 1'b0;
        end else if (en) begin
            unique case (state)
                IDLE: begin
                    if (key_zero) state_nxt = ARMED;
                end
                ARMED: begin
                    if (!key_zero) begin
                        if (STABLE_CYC == 1) begin
                            accept = 1'b1;
                        end else begin
                            state_nxt = CONFIRM;
                            cand_nxt  = key_in;
                            cnt_nxt   = '0;
                        end
                    end
                end
                CONFIRM: begin
                    if (key_zero) begin
                        state_nxt = ARMED;
                    end else if (key_in != cand) begin
                        cand_nxt = key_in;
                        cnt_nxt  = '0;
                    end else if (cnt == CNT_LAST) begin
                        accept = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (key_zero) state_nxt = ARMED;
                end
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase

            // One scored event per press; the last note parks the FSM in DONE
            if (accept) begin
                state_nxt = HELD;
                cnt_nxt   = '0;
                if (key_in == expected_note) begin
                    hit_nxt = 1'b1;
                    if (index == LAST_V) begin
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        index_nxt = index + 1'b1;
                    end
                end else begin
                    miss_nxt = 1'b1;
                end
            end
        end
    end

`ifdef STUDY_MISS_COUNT_EN
    logic [7:0] mc_q, mc_nxt;

    // Saturating miss counter
    always_comb begin
        mc_nxt = mc_q;
        if (restart) begin
            mc_nxt = 8'h00;
        end else if (miss_nxt && (mc_q != 8'hFF)) begin
            mc_nxt = mc_q + 8'h01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mc_q <= 8'h00;
        end else begin
            mc_q <= mc_nxt;
        end
    end

    assign miss_count = mc_q;
`else
    assign miss_count = 8'h00;
`endif

endmodule

// File: tb/tb_study_index_tracker.sv
// Directed bench for study_index_tracker: run-length press model checked every cycle,
// plus hand-computed literal checkpoints.
module tb_study_index_tracker;

    localparam int unsigned NOTE_W = 10;
    localparam int unsigned IDX_W  = 7;
    localparam int unsigned START  = 1;
    localparam int unsigned SLEN   = 3;
    localparam int unsigned STABLE = 4;
`ifdef STUDY_MISS_COUNT_EN
    localparam bit MC_EN = 1'b1;
`else
    localparam bit MC_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b1;
    logic              restart = 1'b0;
    logic [NOTE_W-1:0] expected_note = '0;
    logic [NOTE_W-1:0] key_in = '0;
    logic [IDX_W-1:0]  index;
    logic              hit, miss, done;
    logic [7:0]        miss_count;

    study_index_tracker #(
        .NOTE_W(NOTE_W), .IDX_W(IDX_W), .START_IDX(START),
        .SONG_LEN(SLEN), .STABLE_CYC(STABLE)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .restart(restart),
        .expected_note(expected_note), .key_in(key_in),
        .index(index), .hit(hit), .miss(miss), .done(done),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Score: index -> note
    int song [0:127];
    initial begin
        for (int i = 0; i < 128; i++) song[i] = 0;
        song[1] = 'h011;
        song[2] = 'h033;
        song[3] = 'h044;
    end

    // Model: a press scores once its code has been seen on STABLE enabled cycles in a row,
    // after a released (zero) cycle; then it must be released again.
    bit m_valid = 1'b0;
    int m_idx, m_len, m_key, m_mc;
    bit m_done, m_blocked, m_hit, m_miss;
    int dut_hits = 0, dut_misses = 0;

    always @(posedge clk) begin
        if (m_valid) begin
            dut_hits   += int'(hit);
            dut_misses += int'(miss);
        end
        if (rst || restart) begin
            m_idx = START; m_done = 1'b0; m_blocked = 1'b1; m_len = 0; m_key = 0;
            m_hit = 1'b0; m_miss = 1'b0; m_mc = 0;
            if (rst) m_valid = 1'b1;
        end else if (!en) begin
            m_hit = 1'b0; m_miss = 1'b0;
        end else begin
            m_hit = 1'b0; m_miss = 1'b0;
            if (m_done) begin
                m_len = 0;
            end else if (m_blocked) begin
                if (key_in == 0) m_blocked = 1'b0;
                m_len = 0;
            end else if (key_in == 0) begin
                m_len = 0;
            end else begin
                if (m_len > 0 && int'(key_in) == m_key) m_len++;
                else begin m_key = int'(key_in); m_len = 1; end
                if (m_len == STABLE) begin
                    m_len = 0;
                    m_blocked = 1'b1;
                    if (key_in == expected_note) begin
                        m_hit = 1'b1;
                        if (m_idx == SLEN) m_done = 1'b1;
                        else m_idx++;
                    end else begin
                        m_miss = 1'b1;
                        if (m_mc < 255) m_mc++;
                    end
                end
            end
        end
    end

    // Per-cycle compare, then present the score note for the model's index
    always @(negedge clk) begin
        if (m_valid) begin
            chk("index", int'(index), m_idx);
            chk("hit", int'(hit), int'(m_hit));
            chk("miss", int'(miss), int'(m_miss));
            chk("done", int'(done), int'(m_done));
            chk("miss_count", int'(miss_count), MC_EN ? m_mc : 0);
            chk("hit_miss_excl", int'(hit & miss), 0);
        end
        expected_note = NOTE_W'(song[m_idx]);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int k, input int hold);
        key_in = NOTE_W'(k);
        cyc(hold);
        key_in = '0;
        cyc(2);
    endtask

    int h0, mi0;

    initial begin
        cyc(2);
        rst = 1'b0;
        chk("rst_index", int'(index), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_hit", int'(hit), 0);
        chk("rst_miss_count", int'(miss_count), 0);
        cyc(1);

        // Clean press: hit appears on the 4th cycle after the key shows
        h0 = dut_hits;
        key_in = 'h011;
        cyc(3);
        chk("lat_no_hit_early", int'(hit), 0);
        cyc(1);
        chk("lat_hit", int'(hit), 1);
        cyc(6);
        key_in = '0;
        cyc(2);
        chk("clean_hits", dut_hits - h0, 1);
        chk("clean_index", int'(index), 2);

        restart = 1'b1; cyc(1); restart = 1'b0;
        chk("restart_index", int'(index), 1);

        // Key held across reset release is ignored until re-pressed
        h0 = dut_hits;
        key_in = 'h011; rst = 1'b1; cyc(2); rst = 1'b0;
        cyc(8);
        chk("held_rst_no_hit", dut_hits - h0, 0);
        key_in = '0; cyc(1);
        press('h011, 5);
        chk("held_rst_hits", dut_hits - h0, 1);
        chk("held_rst_index", int'(index), 2);

        // Wrong key
        mi0 = dut_misses;
        press('h022, 4);
        chk("wrong_misses", dut_misses - mi0, 1);
        chk("wrong_index", int'(index), 2);
        chk("wrong_miss_count", int'(miss_count), MC_EN ? 1 : 0);

        // Bounce: 2-cycle glitch produces nothing
        h0 = dut_hits;
        key_in = 'h033; cyc(2); key_in = '0; cyc(1);
        press('h033, 4);
        chk("bounce_hits", dut_hits - h0, 1);
        chk("bounce_index", int'(index), 3);

        // Full song to DONE, then ignored press, then restart
        restart = 1'b1; cyc(1); restart = 1'b0; cyc(1);
        h0 = dut_hits;
        press('h011, 4);
        press('h033, 4);
        press('h044, 4);
        chk("song_hits", dut_hits - h0, 3);
        chk("song_done", int'(done), 1);
        chk("song_index", int'(index), 3);
        h0 = dut_hits; mi0 = dut_misses;
        press('h044, 6);
        press('h077, 6);
        chk("done_no_events", (dut_hits - h0) + (dut_misses - mi0), 0);
        chk("done_index", int'(index), 3);
        restart = 1'b1; cyc(1); restart = 1'b0;
        chk("restart_done", int'(done), 0);
        chk("restart_index2", int'(index), 1);
        cyc(1);

        // en=0 mid-press freezes progress, press resumes afterwards
        mi0 = dut_misses;
        key_in = 'h022; cyc(2);
        en = 1'b0; cyc(5);
        chk("en_freeze_miss", dut_misses - mi0, 0);
        en = 1'b1; cyc(2);
        chk("en_resume_miss", int'(miss), 1);
        key_in = '0; cyc(2);

        // Saturate the miss counter: 256 wrong presses in total
        for (int i = 0; i < 255; i++) press('h022, 4);
        chk("sat_misses", dut_misses - mi0, 256);
        chk("sat_miss_count", int'(miss_count), MC_EN ? 255 : 0);
        chk("sat_index", int'(index), 1);

        // rst and restart together
        key_in = 'h011; restart = 1'b1; rst = 1'b1; cyc(1);
        restart = 1'b0; rst = 1'b0;
        chk("both_index", int'(index), 1);
        chk("both_miss_count", int'(miss_count), 0);
        chk("both_done", int'(done), 0);
        key_in = '0; cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/study_index_tracker.md
STUDY_INDEX_TRACKER -- requirements
Module: study_index_tracker

Interface
REQ-001 Parameter NOTE_W, default 10, width of the note/pitch code and key code.
REQ-002 Parameter IDX_W, default 7, width of the song index.
REQ-003 Parameter START_IDX, default 1, index value after reset or restart.
REQ-004 Parameter SONG_LEN, default 100, last valid index; must satisfy START_IDX <= SONG_LEN <= 2^IDX_W-1.
REQ-005 Parameter STABLE_CYC, default 4, consecutive cycles a key code must hold before it is accepted; minimum 1.
REQ-006 clk  input  1  single system clock; all state updates on the rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 en  input  1  study mode active; 0 freezes all state except the restart path.
REQ-009 restart  input  1  one-cycle request to return to START_IDX without a full reset.
REQ-010 expected_note  input  NOTE_W  note/pitch code for the current index, supplied externally from the score ROM.
REQ-011 key_in  input  NOTE_W  current key code; all-zero means no key pressed.
REQ-012 index  output  IDX_W  current score position, registered.
REQ-013 hit  output  1  one-cycle pulse when the correct key is accepted.
REQ-014 miss  output  1  one-cycle pulse when a wrong key is accepted.
REQ-015 done  output  1  level, high once the key for SONG_LEN has been hit.
REQ-016 miss_count  output  8  saturating count of misses since reset or restart.

Function
REQ-017 FSM states SHALL be IDLE, ARMED, CONFIRM, HELD, DONE; reset state IDLE.
REQ-018 IDLE->ARMED when en=1 and key_in=0; IDLE stays while key_in!=0 so a key held at entry is ignored.
REQ-019 ARMED->CONFIRM when key_in!=0, latching key_in into an internal candidate register and clearing a stability counter.
REQ-020 CONFIRM: counter increments each cycle key_in equals the candidate; any change of key_in returns to ARMED (key_in=0) or restarts CONFIRM with the new candidate (key_in!=0).
REQ-021 When the counter reaches STABLE_CYC-1 with key_in equal to the candidate, the key SHALL be accepted on that edge and the FSM enters HELD.
REQ-022 Accepted key equal to expected_note: hit=1 for one cycle; index increments by 1 in the same edge unless index=SONG_LEN, in which case index holds and the FSM enters DONE instead of HELD.
REQ-023 Accepted key not equal to expected_note: miss=1 for one cycle; index unchanged.
REQ-024 HELD->ARMED only when key_in=0 for one cycle; exactly one hit or miss SHALL be produced per press regardless of hold length.
REQ-025 Latency: hit/miss and index change SHALL occur STABLE_CYC cycles after the first cycle key_in shows the new code.
REQ-026 DONE: done=1, index holds SONG_LEN, key presses ignored, no hit/miss; leaves only via restart or rst.
REQ-027 restart=1 (any state, en ignored): index<=START_IDX, miss_count<=0, done<=0, hit/miss<=0, FSM<=IDLE on that edge.
REQ-028 rst and restart asserted together: rst result, identical values.
REQ-029 en=0: FSM, index, counters hold; hit/miss forced 0; a press in progress resumes from its state when en returns to 1.
REQ-030 index never exceeds SONG_LEN and never wraps.
REQ-031 miss_count saturates at 255; a miss at 255 still pulses miss.
REQ-032 hit and miss SHALL never be high in the same cycle.

Reset
REQ-033 On rst=1 at a rising edge: index=START_IDX, hit=0, miss=0, done=0, miss_count=0, FSM=IDLE, candidate and stability counter cleared.
REQ-034 Reset mid-press SHALL discard the press; the held key produces no event until released and re-pressed.

Configuration
REQ-035 Macro STUDY_MISS_COUNT_EN defined: miss_count behaves per REQ-016/031.
REQ-036 Macro STUDY_MISS_COUNT_EN undefined: miss_count tied to 0, counter logic absent; miss pulse and all other behaviour unchanged.

Verification
REQ-037 Reset, STABLE_CYC=4, expected_note=0x011, key_in 0->0x011 held 10 cycles then 0 -> one hit in 4th cycle of press, index 1->2, no further events.
REQ-038 key_in=0x011 held across reset release -> no hit until key_in=0 then 0x011 pressed again; then index 1->2.
REQ-039 expected_note=0x011, press 0x022 for 4 cycles -> miss pulse, index stays, miss_count 0->1 (0 with macro undefined).
REQ-040 Bounce 0x011 for 2 cycles, 0 for 1, 0x011 for 4 -> exactly one hit, none from the 2-cycle glitch.
REQ-041 SONG_LEN=3: three correct presses -> index 1->2->3, third hit sets done=1, index stays 3; fourth press no event; restart -> index=1, done=0.
REQ-042 256 wrong presses with macro defined -> miss_count=255, 256 miss pulses; en=0 mid-press freezes index and counter.
